// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: reader FSM state encoding, read latency and default geometry.
// Used by synch_fifo, fifo_skid_buf and fifo_burst_reader.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_RD_LAT      = 1;
  localparam int FIFO_PTR_DFLT    = 3;
  localparam int FIFO_WIDTH_DFLT  = 16;
  localparam int FIFO_DEPTH_DFLT  = 8;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry data+last output buffer; push lands the cycle after the FIFO read, visible next cycle.
// Head entry holds stable while out_valid && !out_ready; upstream credit keeps it from overflowing.
module fifo_skid_buf #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  out_valid,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic                  last;
    logic [FIFO_WIDTH-1:0] dat;
  } ent_t;

  ent_t       ent0_q, ent0_d, ent1_q, ent1_d, in_ent;
  logic [1:0] occ_q, occ_d;
  logic       pop;

  assign in_ent    = '{last: push_last, dat: push_data};
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = ent0_q.dat;
  assign out_last  = ent0_q.last;
  assign occupancy = occ_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = in_ent;
        end else begin
          ent0_d = in_ent;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = in_ent;
        else               ent1_d = in_ent;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/synch_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after read_en_i).
// Writes while full and reads while empty are ignored.
module synch_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR   = FIFO_PTR_DFLT,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en_i,
  input  logic [FIFO_WIDTH-1:0] write_data_i,
  input  logic                  read_en_i,
  output logic [FIFO_WIDTH-1:0] read_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_PTR:0]     data_avail_o
);

  localparam logic [FIFO_PTR:0] DEPTH_C = (FIFO_PTR+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] read_data_q;
  logic [FIFO_PTR-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR:0]     count_q;
  logic                  do_wr, do_rd;

  assign full_o       = (count_q == DEPTH_C);
  assign empty_o      = (count_q == '0);
  assign data_avail_o = count_q;
  assign read_data_o  = read_data_q;
  assign do_wr        = write_en_i && !full_o;
  assign do_rd        = read_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= write_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        read_data_q <= mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains synch_fifo in bursts of BURST_LEN (or the current contents on flush) onto a valid/ready stream.
// First beat 3 cycles after the start condition, then 1 beat/cycle; credit-gated pops ride out backpressure.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR   = FIFO_PTR_DFLT,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  input  logic [FIFO_WIDTH-1:0] fifo_read_data,
  output logic                  fifo_read_en,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  burst_done
);

  localparam int            CW     = FIFO_PTR + 1;
  localparam int            BL_C   = (BURST_LEN > FIFO_DEPTH) ? FIFO_DEPTH : BURST_LEN;
  localparam logic [CW-1:0] BURST_C = CW'(BL_C);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          inflight_q, burst_done_q;
  logic [1:0]    occupancy, cnt;
  logic          xfer, credit, rd_en, push_last;

  // cnt counts every word that will occupy the buffer: stored entries plus the one on the FIFO read port.
  assign cnt          = occupancy + {1'b0, inflight_q};
  assign xfer         = out_valid && out_ready;
  assign credit       = (cnt < 2'd2) || ((cnt == 2'd2) && xfer);
  assign rd_en        = (state_q == READ) && (rd_cnt_q < len_q) && !fifo_empty && credit;
  assign push_last    = (wr_cnt_q == (len_q - ONE_C));
  assign fifo_read_en = rd_en;
  assign busy         = (state_q != IDLE);
  assign burst_done   = burst_done_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    flush_pend_d = flush_pend_q;
    if (rd_en)      rd_cnt_d = rd_cnt_q + ONE_C;
    if (inflight_q) wr_cnt_d = wr_cnt_q + ONE_C;
    case (state_q)
      IDLE: begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        if (fifo_data_avail >= BURST_C) begin
          state_d      = READ;
          len_d        = BURST_C;
          flush_pend_d = flush_pend_q || flush;
        end else if (flush || flush_pend_q) begin
          // an empty FIFO means there is nothing to flush, so the request is dropped
          flush_pend_d = 1'b0;
          if (!fifo_empty) begin
            state_d = READ;
            len_d   = fifo_data_avail;
          end
        end
      end
      READ: begin
        flush_pend_d = flush_pend_q || flush;
        if (rd_en && (rd_cnt_q == (len_q - ONE_C))) state_d = DRAIN;
      end
      DRAIN: begin
        flush_pend_d = flush_pend_q || flush;
        if (xfer && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
      inflight_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      flush_pend_q <= flush_pend_d;
      inflight_q   <= rd_en;
      burst_done_q <= (state_q == DRAIN) && xfer && out_last;
    end
  end

  fifo_skid_buf #(
    .FIFO_WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_read_data),
    .push_last (push_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: synch_fifo + fifo_burst_reader pairs with BURST_LEN=4 (pair 0) and BURST_LEN=8 (pair 1).
module tb_fifo_burst_reader;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en, full, empty, ren, flush, ov, ol, ordy, busy, done;
  logic [15:0] wr_dat [2];
  logic [15:0] rdata  [2];
  logic [15:0] od     [2];
  logic [3:0]  avail  [2];

  int errors = 0;
  int checks = 0;

  // monitor state, written only by the negedge monitor
  int          cyc = 0;
  logic [15:0] bdat  [2][64];
  logic        blast [2][64];
  int          bcyc  [2][64];
  int          bn [2], ren_cnt [2], done_cnt [2], viol [2], ov_cnt [2], s_cyc [2];
  int          occ_m [2], infl_m [2];
  logic        stalled [2];
  logic [15:0] st_dat [2];
  logic        st_last [2];
  logic        xf_m;
  localparam int BLV [2] = '{4, 8};

  synch_fifo u_fifo0 (
    .clk(clk), .rst_n(rst_n), .write_en_i(wr_en[0]), .write_data_i(wr_dat[0]),
    .read_en_i(ren[0]), .read_data_o(rdata[0]), .full_o(full[0]), .empty_o(empty[0]),
    .data_avail_o(avail[0])
  );
  fifo_burst_reader #(.BURST_LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty[0]), .fifo_data_avail(avail[0]),
    .fifo_read_data(rdata[0]), .fifo_read_en(ren[0]), .flush(flush[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_ready(ordy[0]),
    .busy(busy[0]), .burst_done(done[0])
  );
  synch_fifo u_fifo1 (
    .clk(clk), .rst_n(rst_n), .write_en_i(wr_en[1]), .write_data_i(wr_dat[1]),
    .read_en_i(ren[1]), .read_data_o(rdata[1]), .full_o(full[1]), .empty_o(empty[1]),
    .data_avail_o(avail[1])
  );
  fifo_burst_reader #(.BURST_LEN(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty[1]), .fifo_data_avail(avail[1]),
    .fifo_read_data(rdata[1]), .fifo_read_en(ren[1]), .flush(flush[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_ready(ordy[1]),
    .busy(busy[1]), .burst_done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      bn[p] = 0; ren_cnt[p] = 0; done_cnt[p] = 0; viol[p] = 0; ov_cnt[p] = 0;
      s_cyc[p] = -100; occ_m[p] = 0; infl_m[p] = 0; stalled[p] = 1'b0;
      st_dat[p] = '0; st_last[p] = 1'b0;
    end
  end

  // Independent buffer-occupancy model and beat recorder.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        occ_m[p] = 0; infl_m[p] = 0; stalled[p] = 1'b0;
      end else begin
        xf_m = ov[p] && ordy[p];
        if (stalled[p] && (!ov[p] || od[p] !== st_dat[p] || ol[p] !== st_last[p])) viol[p] = viol[p] + 1;
        if (ren[p] && (occ_m[p] + infl_m[p] == 2) && !xf_m) viol[p] = viol[p] + 1;
        if (ren[p] && empty[p]) viol[p] = viol[p] + 1;
        if (xf_m && bn[p] < 64) begin
          bdat[p][bn[p]] = od[p]; blast[p][bn[p]] = ol[p]; bcyc[p][bn[p]] = cyc;
          bn[p] = bn[p] + 1;
        end
        if (!busy[p] && (int'(avail[p]) >= BLV[p])) s_cyc[p] = cyc;
        stalled[p] = ov[p] && !ordy[p];
        st_dat[p]  = od[p];
        st_last[p] = ol[p];
        occ_m[p]   = occ_m[p] + infl_m[p] - (xf_m ? 1 : 0);
        infl_m[p]  = ren[p] ? 1 : 0;
        ren_cnt[p]  = ren_cnt[p] + (ren[p] ? 1 : 0);
        done_cnt[p] = done_cnt[p] + (done[p] ? 1 : 0);
        ov_cnt[p]   = ov_cnt[p] + (ov[p] ? 1 : 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [15:0] v, input bit tog);
    wr_en[p]  = 1'b1;
    wr_dat[p] = v;
    if (tog) ordy[p] = ~ordy[p];
    tick();
    wr_en[p] = 1'b0;
  endtask

  task automatic wait_done(input int p, input int target, input bit tog, input string tag);
    int k = 0;
    while (done_cnt[p] < target && k < 300) begin
      if (tog) ordy[p] = ~ordy[p];
      tick();
      k++;
    end
    chk(tag, 32'(done_cnt[p] >= target), 32'd1);
  endtask

  task automatic chk_outs_zero(input int p, input string tag);
    chk({tag, "_valid"}, 32'(ov[p]), 32'd0);
    chk({tag, "_data"},  32'(od[p]), 32'd0);
    chk({tag, "_last"},  32'(ol[p]), 32'd0);
    chk({tag, "_ren"},   32'(ren[p]), 32'd0);
    chk({tag, "_busy"},  32'(busy[p]), 32'd0);
    chk({tag, "_done"},  32'(done[p]), 32'd0);
  endtask

  task automatic chk_beats(input int p, input int b, input int n, input logic [15:0] v0, input int blen);
    logic [15:0] e;
    chk("beat_count", 32'(bn[p] - b), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = v0 + 16'(i);
      chk("beat_data", 32'(bdat[p][b+i]), 32'(e));
      chk("beat_last", 32'(blast[p][b+i]), 32'((i % blen) == blen - 1 || i == n - 1));
    end
  endtask

  initial begin
    int b, r, d, v, o, k;
    logic [15:0] e;
    rst_n = 1'b0; wr_en = '0; flush = '0; ordy = 2'b11;
    wr_dat[0] = '0; wr_dat[1] = '0;
    tick(); tick();
    chk_outs_zero(0, "rst0");
    chk_outs_zero(1, "rst1");
    rst_n = 1'b1;
    tick();

    // full burst of 4
    b = bn[0]; r = ren_cnt[0]; d = done_cnt[0];
    for (int i = 0; i < 4; i++) wr(0, 16'hA001 + 16'(i), 1'b0);
    wait_done(0, d + 1, 1'b0, "full_done_timeout");
    tick(); tick();
    chk_beats(0, b, 4, 16'hA001, 4);
    chk("full_ren_cycles", 32'(ren_cnt[0] - r), 32'd4);
    chk("full_done_pulses", 32'(done_cnt[0] - d), 32'd1);
    chk("full_busy_after", 32'(busy[0]), 32'd0);

    // partial burst only on flush
    b = bn[0]; d = done_cnt[0]; o = ov_cnt[0];
    for (int i = 0; i < 3; i++) wr(0, 16'h0011 + 16'(i), 1'b0);
    repeat (20) tick();
    chk("flush_hold_valid_cycles", 32'(ov_cnt[0] - o), 32'd0);
    chk("flush_hold_busy", 32'(busy[0]), 32'd0);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    wait_done(0, d + 1, 1'b0, "flush_done_timeout");
    tick();
    chk_beats(0, b, 3, 16'h0011, 3);
    chk("flush_busy_after", 32'(busy[0]), 32'd0);

    // backpressure: two bursts with out_ready toggling
    b = bn[0]; d = done_cnt[0]; v = viol[0];
    ordy[0] = 1'b0;
    for (int i = 0; i < 8; i++) wr(0, 16'hC001 + 16'(i), 1'b1);
    wait_done(0, d + 2, 1'b1, "bp_done_timeout");
    ordy[0] = 1'b1;
    tick(); tick();
    chk_beats(0, b, 8, 16'hC001, 4);
    chk("bp_stream_violations", 32'(viol[0] - v), 32'd0);

    // eight words in one go: back-to-back bursts of 4
    b = bn[0]; d = done_cnt[0];
    for (int i = 0; i < 8; i++) wr(0, ~16'(i + 1), 1'b0);
    wait_done(0, d + 2, 1'b0, "fill_done_timeout");
    tick(); tick();
    chk("fill_beat_count", 32'(bn[0] - b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      e = ~16'(i + 1);
      chk("fill_data", 32'(bdat[0][b+i]), 32'(e));
      chk("fill_last", 32'(blast[0][b+i]), 32'(i == 3 || i == 7));
    end
    chk("fill_done_pulses", 32'(done_cnt[0] - d), 32'd2);

    // throughput with BURST_LEN=8
    b = bn[1]; d = done_cnt[1];
    for (int i = 0; i < 8; i++) wr(1, 16'hD001 + 16'(i), 1'b0);
    wait_done(1, d + 1, 1'b0, "tput_done_timeout");
    tick();
    chk_beats(1, b, 8, 16'hD001, 8);
    for (int i = 0; i < 8; i++) chk("tput_beat_cycle", 32'(bcyc[1][b+i] - s_cyc[1]), 32'(3 + i));

    // reset in the middle of a burst
    b = bn[0]; k = 0;
    for (int i = 0; i < 4; i++) wr(0, 16'h9001 + 16'(i), 1'b0);
    while (bn[0] < b + 2 && k < 100) begin tick(); k++; end
    chk("rstmid_two_beats_seen", 32'(bn[0] >= b + 2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero(0, "rstmid_a");
    tick();
    chk_outs_zero(0, "rstmid_b");
    chk("rstmid_fifo_empty", 32'(empty[0]), 32'd1);
    rst_n = 1'b1;
    tick();
    b = bn[0]; d = done_cnt[0];
    for (int i = 0; i < 4; i++) wr(0, 16'hB001 + 16'(i), 1'b0);
    wait_done(0, d + 1, 1'b0, "rstmid_done_timeout");
    tick(); tick();
    chk_beats(0, b, 4, 16'hB001, 4);
    chk("rstmid_busy_after", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
